// File: rtl/vertex_output_collector.sv
// rtl/vertex_output_collector.sv - reassembles x/y/z/w component beats into vertices behind a small FIFO
module vertex_output_collector #(
    parameter int M     = 11,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic signed [M-1:0]        in_component,
    input  logic                       in_valid,
    input  logic                       flush,
    output logic signed [M-1:0]        out_x,
    output logic signed [M-1:0]        out_y,
    output logic signed [M-1:0]        out_z,
    output logic signed [M-1:0]        out_w,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [1:0]         beat;
    logic [M-1:0]       x_reg, y_reg, z_reg;
    logic [4*M-1:0]     mem [DEPTH];
    logic [AW-1:0]      rd_ptr, wr_ptr;
    logic [CW-1:0]      count;
    logic               overflow_r;

    logic push, pop, full, do_write;
    logic [4*M-1:0] head;

    assign push     = in_valid && (beat == 2'd3);
    assign pop      = out_valid && out_ready;
    assign full     = (count == CW'(DEPTH));
    // A push at full still succeeds if the head leaves in the same cycle.
    assign do_write = push && (!full || pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            beat       <= 2'd0;
            x_reg      <= '0;
            y_reg      <= '0;
            z_reg      <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            overflow_r <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            beat   <= 2'd0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (in_valid) begin
                beat <= beat + 2'd1;
                case (beat)
                    2'd0:    x_reg <= in_component;
                    2'd1:    y_reg <= in_component;
                    2'd2:    z_reg <= in_component;
                    default: ;
                endcase
            end
            if (do_write) begin
                mem[wr_ptr] <= {x_reg, y_reg, z_reg, in_component};
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !do_write) begin
                overflow_r <= 1'b1;
            end
            case ({do_write, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
        end
    end

    assign head      = mem[rd_ptr];
    assign out_x     = head[4*M-1:3*M];
    assign out_y     = head[3*M-1:2*M];
    assign out_z     = head[2*M-1:M];
    assign out_w     = head[M-1:0];
    assign out_valid = (count != '0);
    assign level     = count;
    assign overflow  = overflow_r;
endmodule

// File: tb/tb_vertex_output_collector.sv
// tb/tb_vertex_output_collector.sv - directed self-checking bench for vertex_output_collector
module tb_vertex_output_collector;
    localparam int M     = 11;
    localparam int DEPTH = 4;

    logic                clk = 1'b0;
    logic                reset;
    logic signed [M-1:0] in_component;
    logic                in_valid;
    logic                flush;
    logic signed [M-1:0] out_x, out_y, out_z, out_w;
    logic                out_valid;
    logic                out_ready;
    logic [2:0]          level;
    logic                overflow;

    int checks = 0;
    int errors = 0;

    vertex_output_collector #(.M(M), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .in_component(in_component), .in_valid(in_valid),
        .flush(flush), .out_x(out_x), .out_y(out_y), .out_z(out_z), .out_w(out_w),
        .out_valid(out_valid), .out_ready(out_ready), .level(level), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_vtx(input string tag, input int a, input int b, input int c, input int d);
        logic [4*M-1:0] e;
        e = {M'(a), M'(b), M'(c), M'(d)};
        check(tag, {out_x, out_y, out_z, out_w}, e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input int v);
        in_component = M'(v);
        in_valid     = 1'b1;
        tick();
        in_valid     = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic vtx(input int a, input int b, input int c, input int d);
        beat(a); beat(b); beat(c); beat(d);
    endtask

    task automatic pop_one();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        reset = 1'b1; in_component = '0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        tick(); tick();
        reset = 1'b0;
        check("rst_valid", out_valid, 0);
        check("rst_level", level, 0);
        check("rst_ovf", overflow, 0);
        check_vtx("rst_data", 0, 0, 0, 0);

        // Single vertex
        beat(5); beat(-3); beat(100);
        check("single_early", out_valid, 0);
        beat(1);
        check("single_valid", out_valid, 1);
        check_vtx("single_data", 5, -3, 100, 1);
        check("single_level", level, 1);
        pop_one();
        check("single_pop_valid", out_valid, 0);
        check("single_pop_level", level, 0);

        // Gapped beats
        beat(7); idle(2); beat(-1024); beat(1023); idle(1);
        check("gap_early", out_valid, 0);
        beat(0);
        check("gap_valid", out_valid, 1);
        check_vtx("gap_data", 7, -1024, 1023, 0);
        check("gap_level", level, 1);
        pop_one();
        check("gap_drain", level, 0);

        // Overflow with out_ready low
        for (int k = 1; k <= 4; k++) vtx(10*k+1, 10*k+2, 10*k+3, 10*k+4);
        check("ovf_full_level", level, 4);
        check("ovf_not_yet", overflow, 0);
        vtx(51, 52, 53, 54);
        check("ovf_level", level, 4);
        check("ovf_set", overflow, 1);
        for (int k = 1; k <= 4; k++) begin
            check_vtx("ovf_order", 10*k+1, 10*k+2, 10*k+3, 10*k+4);
            pop_one();
        end
        check("ovf_empty", out_valid, 0);
        vtx(61, 62, 63, 64);
        check_vtx("ovf_align", 61, 62, 63, 64);
        check("ovf_sticky", overflow, 1);
        pop_one();

        // Reset mid-stream with overflow set and three vertices stored
        vtx(1, 1, 1, 1); vtx(2, 2, 2, 2); vtx(3, 3, 3, 3);
        beat(9);
        check("pre_rst_level", level, 3);
        check("pre_rst_ovf", overflow, 1);
        reset = 1'b1; tick(); reset = 1'b0;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_level", level, 0);
        check("mid_rst_ovf", overflow, 0);
        check_vtx("mid_rst_data", 0, 0, 0, 0);
        vtx(1, 2, 3, 4);
        check_vtx("post_rst_vtx", 1, 2, 3, 4);
        check("post_rst_level", level, 1);
        pop_one();

        // Full with simultaneous push and pop
        for (int k = 1; k <= 4; k++) vtx(100+k, 200+k, 300+k, -k);
        check("sim_full", level, 4);
        beat(105); beat(205); beat(305);
        out_ready = 1'b1;
        beat(-5);
        out_ready = 1'b0;
        check("sim_ovf", overflow, 0);
        check("sim_level", level, 4);
        for (int k = 2; k <= 5; k++) begin
            check_vtx("sim_order", 100+k, 200+k, 300+k, -k);
            pop_one();
        end
        check("sim_drained", level, 0);

        // Flush mid-vertex, with a beat presented in the flush cycle
        vtx(21, 22, 23, 24);
        beat(9); beat(9);
        flush = 1'b1; in_valid = 1'b1; in_component = M'(9);
        tick();
        flush = 1'b0; in_valid = 1'b0;
        check("flush_level", level, 0);
        check("flush_valid", out_valid, 0);
        check("flush_ovf", overflow, 0);
        vtx(1, 2, 3, 4);
        check_vtx("flush_realign", 1, 2, 3, 4);
        check("flush_after_level", level, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
